// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - light codes, lamp encodings, fault codes and state encoding
package traffic_light_pkg;

  localparam logic [1:0] RED          = 2'b00;
  localparam logic [1:0] YELLOW       = 2'b01;
  localparam logic [1:0] GREEN        = 2'b10;
  localparam logic [1:0] BLINKING_RED = 2'b11;

  localparam logic [2:0] CAR_RED = 3'b100;
  localparam logic [2:0] CAR_YEL = 3'b010;
  localparam logic [2:0] CAR_GRN = 3'b001;
  localparam logic [2:0] CAR_ALL = 3'b111;
  localparam logic [1:0] PED_RED = 2'b10;
  localparam logic [1:0] PED_GRN = 2'b01;
  localparam logic [1:0] PED_OFF = 2'b00;
  localparam logic [1:0] PED_ALL = 2'b11;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_CAR  = 2'b01;
  localparam logic [1:0] FC_PED  = 2'b10;
  localparam logic [1:0] FC_ILL  = 2'b11;

  localparam logic [1:0] S_NORMAL  = 2'b00;
  localparam logic [1:0] S_FAULT   = 2'b01;
  localparam logic [1:0] S_RECOVER = 2'b10;

  // Highest-priority fault cause of a code combination; FC_NONE means a good cycle.
  function automatic logic [1:0] fault_cause(input logic [1:0] a, input logic [1:0] b,
                                             input logic [1:0] pa, input logic [1:0] pb);
    if (a != RED && b != RED)
      return FC_CAR;
    else if ((a != RED && pa == GREEN) || (b != RED && pb == GREEN))
      return FC_PED;
    else if (pa == YELLOW || pb == YELLOW)
      return FC_ILL;
    else
      return FC_NONE;
  endfunction

  function automatic logic [2:0] car_decode(input logic [1:0] code, input logic phase);
    case (code)
      RED:     return CAR_RED;
      YELLOW:  return CAR_YEL;
      GREEN:   return CAR_GRN;
      default: return {phase, 2'b00};
    endcase
  endfunction

  // YELLOW never reaches here in a good cycle; it maps to red for completeness.
  function automatic logic [1:0] ped_decode(input logic [1:0] code, input logic phase);
    case (code)
      GREEN:        return PED_GRN;
      BLINKING_RED: return {phase, 1'b0};
      default:      return PED_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lamp_driver_if.sv
// rtl/traffic_lamp_driver_if.sv - code/lamp bundle between controller and lamp driver (LAMP_TEST_EN adds LAMP_TEST)
interface traffic_lamp_driver_if;
  logic [1:0] A;
  logic [1:0] B;
  logic [1:0] PA;
  logic [1:0] PB;
  logic       CLR;
`ifdef LAMP_TEST_EN
  logic       LAMP_TEST;
`endif
  logic [2:0] A_LAMP;
  logic [2:0] B_LAMP;
  logic [1:0] PA_LAMP;
  logic [1:0] PB_LAMP;
  logic       FAULT;
  logic [1:0] FAULT_CODE;

`ifdef LAMP_TEST_EN
  modport master (output A, B, PA, PB, CLR, LAMP_TEST,
                  input  A_LAMP, B_LAMP, PA_LAMP, PB_LAMP, FAULT, FAULT_CODE);
  modport slave  (input  A, B, PA, PB, CLR, LAMP_TEST,
                  output A_LAMP, B_LAMP, PA_LAMP, PB_LAMP, FAULT, FAULT_CODE);
`else
  modport master (output A, B, PA, PB, CLR,
                  input  A_LAMP, B_LAMP, PA_LAMP, PB_LAMP, FAULT, FAULT_CODE);
  modport slave  (input  A, B, PA, PB, CLR,
                  output A_LAMP, B_LAMP, PA_LAMP, PB_LAMP, FAULT, FAULT_CODE);
`endif
endinterface

// File: rtl/traffic_blink_gen.sv
// rtl/traffic_blink_gen.sv - free-running blink phase, toggles every BLINK_HALF cycles, starts on
module traffic_blink_gen #(
  parameter int BLINK_HALF = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic PHASE
);
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      PHASE <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      PHASE <= ~PHASE;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/traffic_lamp_driver.sv
// rtl/traffic_lamp_driver.sv - lamp decode plus latched safety monitor; LAMP_TEST_EN adds lamp test
module traffic_lamp_driver #(
  parameter int BLINK_HALF      = 4,
  parameter int CONFLICT_FILTER = 2,
  parameter int RECOVER_CYCLES  = 8
) (
  input logic                  CLK,
  input logic                  RST,
  traffic_lamp_driver_if.slave bus
);
  import traffic_light_pkg::*;

  localparam logic [3:0] FILT_LIMIT = 4'(CONFLICT_FILTER);
  localparam logic [7:0] REC_LIMIT  = 8'(RECOVER_CYCLES);

  logic       phase;
  logic [1:0] state;
  logic [3:0] filt_cnt;
  logic [7:0] rec_cnt;
  logic [2:0] a_lamp, b_lamp;
  logic [1:0] pa_lamp, pb_lamp;
  logic       fault;
  logic [1:0] fault_code;
  logic [1:0] cause;
  logic       bad;
  logic       test_on;

  traffic_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .CLK  (CLK),
    .RST  (RST),
    .PHASE(phase)
  );

  always_comb begin
    cause = fault_cause(bus.A, bus.B, bus.PA, bus.PB);
    bad   = (cause != FC_NONE);
  end

`ifdef LAMP_TEST_EN
  assign test_on = bus.LAMP_TEST;
`else
  assign test_on = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_NORMAL;
      filt_cnt   <= '0;
      rec_cnt    <= '0;
      a_lamp     <= CAR_RED;
      b_lamp     <= CAR_RED;
      pa_lamp    <= PED_RED;
      pb_lamp    <= PED_RED;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      case (state)
        S_NORMAL: begin
          // Bad cycles freeze the lamps; the cycle that fills the filter enters FAULT.
          if (bad) begin
            if (filt_cnt + 4'd1 == FILT_LIMIT) begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= cause;
              filt_cnt   <= '0;
            end else begin
              filt_cnt   <= filt_cnt + 4'd1;
            end
          end else begin
            filt_cnt <= '0;
            if (test_on) begin
              a_lamp  <= CAR_ALL;
              b_lamp  <= CAR_ALL;
              pa_lamp <= PED_ALL;
              pb_lamp <= PED_ALL;
            end else begin
              a_lamp  <= car_decode(bus.A, phase);
              b_lamp  <= car_decode(bus.B, phase);
              pa_lamp <= ped_decode(bus.PA, phase);
              pb_lamp <= ped_decode(bus.PB, phase);
            end
          end
        end
        S_FAULT: begin
          a_lamp  <= {1'b0, phase, 1'b0};
          b_lamp  <= {1'b0, phase, 1'b0};
          pa_lamp <= PED_OFF;
          pb_lamp <= PED_OFF;
          if (bus.CLR) begin
            state   <= S_RECOVER;
            rec_cnt <= '0;
          end
        end
        S_RECOVER: begin
          a_lamp  <= CAR_RED;
          b_lamp  <= CAR_RED;
          pa_lamp <= PED_RED;
          pb_lamp <= PED_RED;
          if (bad) begin
            state <= S_FAULT;
          end else if (rec_cnt + 8'd1 == REC_LIMIT) begin
            state      <= S_NORMAL;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            rec_cnt    <= '0;
          end else begin
            rec_cnt <= rec_cnt + 8'd1;
          end
        end
        default: state <= S_NORMAL;
      endcase
    end
  end

  assign bus.A_LAMP     = a_lamp;
  assign bus.B_LAMP     = b_lamp;
  assign bus.PA_LAMP    = pa_lamp;
  assign bus.PB_LAMP    = pb_lamp;
  assign bus.FAULT      = fault;
  assign bus.FAULT_CODE = fault_code;
endmodule

// File: tb/tb_traffic_lamp_driver.sv
// tb/tb_traffic_lamp_driver.sv - randomized bench against a behavioural lamp driver model
module tb_traffic_lamp_driver;
  localparam int BH   = 4;
  localparam int FILT = 2;
  localparam int REC  = 8;

  localparam logic [1:0] C_RED = 2'd0, C_YEL = 2'd1, C_GRN = 2'd2, C_BLK = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  traffic_lamp_driver_if bus();

  traffic_lamp_driver dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: mode 0 normal, 1 fault, 2 recover.
  int m_mode, m_bad_run, m_good_run, m_edges;
  int m_a, m_b, m_pa, m_pb, m_fault, m_code;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int car_model(input int code, input int ph);
    int tbl[4] = '{4, 2, 1, 0};
    return (code == 3) ? ph * 4 : tbl[code];
  endfunction

  function automatic int ped_model(input int code, input int ph);
    if (code == 2) return 1;
    if (code == 3) return ph * 2;
    return 2;
  endfunction

  function automatic int cause_model(input int a, input int b, input int pa, input int pb);
    if (a != 0 && b != 0) return 1;
    if ((a != 0 && pa == 2) || (b != 0 && pb == 2)) return 2;
    if (pa == 1 || pb == 1) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bad_run = 0; m_good_run = 0; m_edges = 0;
    m_a = 4; m_b = 4; m_pa = 2; m_pb = 2; m_fault = 0; m_code = 0;
  endtask

  task automatic model_edge(input int a, input int b, input int pa, input int pb, input int clr);
    int ph, c;
    ph = ((m_edges / BH) % 2 == 0) ? 1 : 0;
    c  = cause_model(a, b, pa, pb);
    if (m_mode == 0) begin
      if (c == 0) begin
        m_bad_run = 0;
        m_a = car_model(a, ph); m_b = car_model(b, ph);
        m_pa = ped_model(pa, ph); m_pb = ped_model(pb, ph);
      end else begin
        m_bad_run++;
        if (m_bad_run >= FILT) begin
          m_mode = 1; m_fault = 1; m_code = c; m_bad_run = 0;
        end
      end
    end else if (m_mode == 1) begin
      m_a = ph * 2; m_b = ph * 2; m_pa = 0; m_pb = 0;
      if (clr != 0) begin
        m_mode = 2; m_good_run = 0;
      end
    end else begin
      m_a = 4; m_b = 4; m_pa = 2; m_pb = 2;
      if (c != 0) m_mode = 1;
      else begin
        m_good_run++;
        if (m_good_run >= REC) begin
          m_mode = 0; m_fault = 0; m_code = 0;
        end
      end
    end
    m_edges++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a_lamp"},  int'(bus.A_LAMP),     m_a);
    check({tag, ".b_lamp"},  int'(bus.B_LAMP),     m_b);
    check({tag, ".pa_lamp"}, int'(bus.PA_LAMP),    m_pa);
    check({tag, ".pb_lamp"}, int'(bus.PB_LAMP),    m_pb);
    check({tag, ".fault"},   int'(bus.FAULT),      m_fault);
    check({tag, ".code"},    int'(bus.FAULT_CODE), m_code);
  endtask

  // Inputs change just after the falling edge; outputs are checked at the next falling edge.
  task automatic step(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] pa, input logic [1:0] pb, input logic clr);
    bus.A = a; bus.B = b; bus.PA = pa; bus.PB = pb; bus.CLR = clr;
    model_edge(int'(a), int'(b), int'(pa), int'(pb), int'(clr));
    @(posedge CLK);
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic legal(output logic [1:0] a, output logic [1:0] b,
                       output logic [1:0] pa, output logic [1:0] pb);
    logic [1:0] car;
    logic [1:0] ped_ok[3];
    car = 2'($urandom_range(0, 3));
    ped_ok = '{C_RED, C_GRN, C_BLK};
    if ($urandom_range(0, 1) == 0) begin a = car; b = C_RED; end
    else begin a = C_RED; b = car; end
    pa = (a == C_RED) ? ped_ok[$urandom_range(0, 2)] : ((($urandom_range(0, 1)) != 0) ? C_RED : C_BLK);
    pb = (b == C_RED) ? ped_ok[$urandom_range(0, 2)] : ((($urandom_range(0, 1)) != 0) ? C_RED : C_BLK);
  endtask

  initial begin
    logic [1:0] a, b, pa, pb;
    bus.A = C_RED; bus.B = C_RED; bus.PA = C_RED; bus.PB = C_RED; bus.CLR = 1'b0;
`ifdef LAMP_TEST_EN
    bus.LAMP_TEST = 1'b0;
`endif
    @(negedge CLK);
    do_reset("reset");

    step("decode", C_GRN, C_RED, C_RED, C_GRN, 1'b0);
    check("decode.a_const", int'(bus.A_LAMP), 1);
    check("decode.pb_const", int'(bus.PB_LAMP), 1);

    for (int i = 0; i < 16; i++) step("blink", C_RED, C_RED, C_RED, C_BLK, 1'b0);

    step("glitch1", C_GRN, C_YEL, C_RED, C_RED, 1'b0);
    step("glitch1_ok", C_GRN, C_RED, C_RED, C_RED, 1'b0);
    check("glitch1.fault", int'(bus.FAULT), 0);
    step("conf1", C_GRN, C_YEL, C_RED, C_RED, 1'b0);
    step("conf2", C_GRN, C_YEL, C_RED, C_RED, 1'b0);
    check("conf.fault", int'(bus.FAULT), 1);
    check("conf.code", int'(bus.FAULT_CODE), 1);
    for (int i = 0; i < 6; i++) step("faulted", C_GRN, C_RED, C_RED, C_RED, 1'b0);

    step("clr", C_RED, C_RED, C_RED, C_RED, 1'b1);
    for (int i = 0; i < REC; i++) step("recover", C_RED, C_GRN, C_RED, C_RED, 1'b0);
    check("recover.fault", int'(bus.FAULT), 0);
    step("resume", C_RED, C_GRN, C_RED, C_RED, 1'b0);
    check("resume.b_lamp", int'(bus.B_LAMP), 1);

    step("reconf1", C_GRN, C_GRN, C_RED, C_RED, 1'b0);
    step("reconf2", C_GRN, C_GRN, C_RED, C_RED, 1'b0);
    step("clr2", C_RED, C_RED, C_RED, C_RED, 1'b1);
    for (int i = 0; i < 4; i++) step("rec2", C_RED, C_RED, C_RED, C_RED, 1'b0);
    step("rec2_bad", C_RED, C_RED, C_YEL, C_RED, 1'b0);
    check("rec2_bad.code", int'(bus.FAULT_CODE), 1);
    step("rec2_fault", C_RED, C_RED, C_RED, C_RED, 1'b0);
    check("rec2_fault.pa", int'(bus.PA_LAMP), 0);

    @(negedge CLK);
    do_reset("reset2");
    model_reset();
    step("prio1", C_GRN, C_RED, C_GRN, C_YEL, 1'b0);
    step("prio2", C_GRN, C_RED, C_GRN, C_YEL, 1'b0);
    check("prio.code", int'(bus.FAULT_CODE), 2);

    step("clr3", C_RED, C_RED, C_RED, C_RED, 1'b1);
    step("rec3", C_RED, C_RED, C_RED, C_RED, 1'b0);
    step("rec3", C_RED, C_RED, C_RED, C_RED, 1'b0);
    RST = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst.fault", int'(bus.FAULT), 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 8) legal(a, b, pa, pb);
      else begin
        a = 2'($urandom); b = 2'($urandom); pa = 2'($urandom); pb = 2'($urandom);
      end
      step("rand", a, b, pa, pb, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/traffic_lamp_driver.md
Name: traffic_lamp_driver

Overview:
- Consumes the four 2-bit light codes (A, B, PA, PB) from the intersection controller and drives the physical lamp lines: three lamps (R/Y/G) per car head, two lamps (R/G) per pedestrian head.
- Generates the blink waveform for the BLINKING_RED code.
- Acts as an independent safety monitor. Conflicting or illegal code combinations force a latched flashing-yellow fault mode, which is left only through an explicit clear and a recovery period.

Parameters:
- BLINK_HALF, 4: cycles per blink half-period; blink period is 2*BLINK_HALF.
- CONFLICT_FILTER, 2: consecutive bad cycles required before entering fault; legal range 1..15.
- RECOVER_CYCLES, 8: consecutive good cycles in RECOVER required before returning to NORMAL; legal range 1..255.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- A  input  2  car head A code: 00 RED, 01 YELLOW, 10 GREEN, 11 BLINKING_RED
- B  input  2  car head B code, same encoding
- PA  input  2  pedestrian head A code, same encoding
- PB  input  2  pedestrian head B code, same encoding
- CLR  input  1  fault clear request; sampled only in FAULT
- A_LAMP  output  3  {R,Y,G} lamp enables, car head A
- B_LAMP  output  3  {R,Y,G} lamp enables, car head B
- PA_LAMP  output  2  {R,G} lamp enables, pedestrian head A
- PB_LAMP  output  2  {R,G} lamp enables, pedestrian head B
- FAULT  output  1  high in FAULT and RECOVER
- FAULT_CODE  output  2  first fault cause: 00 none, 01 car conflict, 10 pedestrian conflict, 11 illegal pedestrian code

Behaviour:
- All outputs are registered. Latency is 1 cycle from the input code to the lamp outputs.
- Reset values:
  - A_LAMP=100, B_LAMP=100, PA_LAMP=10, PB_LAMP=10
  - FAULT=0, FAULT_CODE=00
  - state=NORMAL, blink phase=1 (on), blink counter=0, filter counter=0, recovery counter=0
- Blink generator:
  - Free-running counter 0..BLINK_HALF-1. When it wraps, phase toggles.
  - Runs in every state and restarts only on RST.
- Bad condition, evaluated combinationally every cycle:
  - car conflict: A!=RED and B!=RED
  - pedestrian conflict: (A!=RED and PA==GREEN) or (B!=RED and PB==GREEN)
  - illegal pedestrian code: PA==YELLOW or PB==YELLOW
  - Cause priority when several hold at once: car (01) > pedestrian (10) > illegal (11).
- Code-to-lamp decode in NORMAL, good cycles:
  - Car heads: RED gives 100, YELLOW gives 010, GREEN gives 001, BLINKING_RED gives {phase,0,0}.
  - Pedestrian heads: RED gives 10, GREEN gives 01, BLINKING_RED gives {phase,0}.
- State NORMAL:
  - Good cycle: decode lamps and clear the filter counter.
  - Bad cycle: hold all lamp outputs at their previous values and increment the filter counter.
  - When the filter counter reaches CONFLICT_FILTER: go to FAULT, latch FAULT_CODE with the cause of that cycle, set FAULT=1.
  - A good cycle before that point clears the counter and decoding resumes.
- State FAULT:
  - A_LAMP={0,phase,0}, B_LAMP={0,phase,0}; PA_LAMP=00, PB_LAMP=00.
  - FAULT_CODE holds its latched value.
  - CLR=1 moves to RECOVER and clears the recovery counter.
  - Input codes are otherwise ignored.
- State RECOVER:
  - All heads steady red: 100/100/10/10. FAULT stays 1.
  - Each good cycle increments the recovery counter.
  - Any bad cycle returns to FAULT. FAULT_CODE keeps its original value and is not overwritten.
  - When the counter reaches RECOVER_CYCLES: go to NORMAL, set FAULT=0 and FAULT_CODE=00, and restart decode on the next cycle.
- CLR has no effect outside FAULT.
- RST asserted at any time, including mid-fault or mid-recovery, returns all registers to their reset values immediately.

Optional Feature:
- Macro: LAMP_TEST_EN
- When defined:
  - Adds input LAMP_TEST (1 bit).
  - In NORMAL with LAMP_TEST=1, all lamps are driven on (111/111/11/11) while conflict monitoring and filtering continue.
  - LAMP_TEST is ignored in FAULT and RECOVER.
- When undefined: no port and no logic are added.

Decomposition:
- Package traffic_light_pkg holds:
  - the color code constants RED/YELLOW/GREEN/BLINKING_RED
  - the car and pedestrian lamp encodings
  - the FAULT_CODE values
  - the state encoding: NORMAL=00, FAULT=01, RECOVER=10
- One sub-module: traffic_blink_gen (parameter BLINK_HALF, ports CLK, RST, output PHASE).

Test Plan:
- Reset, then A=GREEN, B=RED, PA=RED, PB=GREEN → next cycle A_LAMP=001, B_LAMP=100, PA_LAMP=10, PB_LAMP=01, FAULT=0.
- PB=BLINKING_RED held for 16 cycles with BLINK_HALF=4 → PB_LAMP red bit toggles every 4 cycles, starting high after reset.
- A=GREEN and B=YELLOW for 1 cycle, then legal again → no fault, lamps frozen for that 1 cycle. The same pair held 2 cycles → FAULT=1, FAULT_CODE=01, car yellows blink, pedestrian lamps 00.
- A=GREEN, PA=GREEN and PB=YELLOW held simultaneously → FAULT_CODE=10 (priority over 11).
- In FAULT pulse CLR, hold legal codes 8 cycles → FAULT drops after the 8th good cycle, decode resumes. Repeat with a bad code at recovery cycle 5 → back to FAULT with FAULT_CODE unchanged.
- Assert RST during RECOVER → next observation FAULT=0, FAULT_CODE=00, lamps 100/100/10/10.
